// File: rtl/gpr.sv
// gpr: 32 x 32-bit register file, register 0 reads as zero.
// Two combinational read ports, one synchronous write port.
module gpr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] num_write,
  input  logic [DATA_WIDTH-1:0] data_write
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] gp_registers [0:NREGS-1];

  logic wr_en_d;
  logic rs_zero_d;
  logic rt_zero_d;

  // Writes to index 0 are dropped so it stays zero once reset.
  always_comb begin
    wr_en_d   = reg_write && (num_write != '0);
    rs_zero_d = (rs == '0);
    rt_zero_d = (rt == '0);
  end

  // Reset clears every entry and wins over a same-cycle write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        gp_registers[i] <= '0;
      end
    end else if (wr_en_d) begin
      gp_registers[num_write] <= data_write;
    end
  end

  // Index 0 is forced so it reads zero even before the first reset.
  always_comb begin
    a = rs_zero_d ? '0 : gp_registers[rs];
    b = rt_zero_d ? '0 : gp_registers[rt];
  end

endmodule

// File: tb/tb_gpr.sv
// tb_gpr: directed vectors for the gpr register file.
// Inputs change on the falling edge, outputs sampled off-edge.
module tb_gpr;

  logic        clock;
  logic        reset;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] a;
  logic [31:0] b;
  logic        reg_write;
  logic [4:0]  num_write;
  logic [31:0] data_write;

  int n_chk;
  int n_pass;

  gpr dut (
    .clock      (clock),
    .reset      (reset),
    .rs         (rs),
    .rt         (rt),
    .a          (a),
    .b          (b),
    .reg_write  (reg_write),
    .num_write  (num_write),
    .data_write (data_write)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    reset      = 1'b1;
    rs         = '0;
    rt         = '0;
    reg_write  = 1'b0;
    num_write  = '0;
    data_write = '0;

    // reset, then every index reads 0 on both ports
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i);
      rt = 5'(i);
      #1;
      chk($sformatf("rst_a[%0d]", i), a, 32'h0);
      chk($sformatf("rst_b[%0d]", i), b, 32'h0);
    end

    // fill: reg i <= i
    for (int i = 1; i < 32; i++) begin
      @(negedge clock);
      reg_write  = 1'b1;
      num_write  = 5'(i);
      data_write = 32'(i);
    end
    @(negedge clock);
    reg_write = 1'b0;
    chk("fill_r31", dut.gp_registers[31], 32'h0000001f);
    for (int i = 1; i < 32; i++) begin
      rs = 5'(i);
      #1;
      chk($sformatf("fill[%0d]", i), a, 32'(i));
    end

    // write disabled: shifted address/data must not land
    for (int i = 1; i < 32; i++) begin
      @(negedge clock);
      reg_write  = 1'b0;
      num_write  = 5'(i + 1);
      data_write = 32'(i);
    end
    @(negedge clock);
    chk("wdis_r2", dut.gp_registers[2], 32'h00000002);
    for (int i = 1; i < 32; i++) begin
      rt = 5'(i);
      #1;
      chk($sformatf("wdis[%0d]", i), b, 32'(i));
    end

    // dual read, rs=i, rt=31-i
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i);
      rt = 5'(31 - i);
      #1;
      chk($sformatf("dual_a[%0d]", i), a, 32'(i));
      chk($sformatf("dual_b[%0d]", i), b, 32'(31 - i));
    end

    // rs == rt
    rs = 5'd17;
    rt = 5'd17;
    #1;
    chk("same_a", a, 32'd17);
    chk("same_b", b, 32'd17);

    // zero register ignores writes
    @(negedge clock);
    reg_write  = 1'b1;
    num_write  = 5'd0;
    data_write = 32'hdeadbeef;
    rs         = 5'd0;
    @(negedge clock);
    reg_write = 1'b0;
    #1;
    chk("zero_a", a, 32'h0);

    // write reg 9 while reading 7: no interaction
    rs         = 5'd7;
    reg_write  = 1'b1;
    num_write  = 5'd9;
    data_write = 32'h99999999;
    #1;
    chk("indep_pre", a, 32'd7);
    @(posedge clock);
    #1;
    chk("indep_post", a, 32'd7);
    rt = 5'd9;
    #1;
    chk("indep_w9", b, 32'h99999999);

    // read-during-write on reg 5: old value until the edge
    @(negedge clock);
    rs         = 5'd5;
    num_write  = 5'd5;
    data_write = 32'ha5a5a5a5;
    reg_write  = 1'b1;
    #1;
    chk("rdw_pre", a, 32'h00000005);
    @(posedge clock);
    #1;
    chk("rdw_post", a, 32'ha5a5a5a5);

    // reset with a same-cycle write: reset wins, only at the edge
    @(negedge clock);
    reset      = 1'b1;
    reg_write  = 1'b1;
    num_write  = 5'd5;
    data_write = 32'h12345678;
    rt         = 5'd31;
    #1;
    chk("rst_mid_a", a, 32'ha5a5a5a5);
    chk("rst_mid_b", b, 32'h0000001f);
    @(posedge clock);
    #1;
    chk("rst_win_a", a, 32'h0);
    chk("rst_win_b", b, 32'h0);
    @(negedge clock);
    reset     = 1'b0;
    reg_write = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
